// File: rtl/wb_intercon_n.sv
`default_nettype none
// ============================================================================
// Module   : wb_intercon_n
// Purpose  : Single-master, NSLAVE-slave Wishbone B4 pipelined interconnect.
//            Address windows are decoded with per-slave base/mask pairs, up to
//            MAX_OUT accepted requests are tracked in order, unmapped
//            addresses get an internal error response and a watchdog errors
//            out requests that a slave never answers.
// Ports    : clk, rst_n                 clock, asynchronous active-low reset
//            m_cyc/m_stb/m_we/m_adr/m_dat_w   master request
//            m_stall/m_ack/m_err/m_dat_r      master status and response
//            s_cyc/s_stb [NSLAVE]      per-slave cycle and strobe
//            s_we/s_adr/s_dat_w        broadcast copies of the master request
//            s_stall/s_ack/s_err [NSLAVE], s_dat_r [NSLAVE*DW]  slave status
// Revision : 1.0 - initial release
// ============================================================================
module wb_intercon_n #(
  parameter int                   NSLAVE   = 5,
  parameter int                   AW       = 16,
  parameter int                   DW       = 16,
  parameter logic [NSLAVE*AW-1:0] SLV_BASE = {16'h3800, 16'h3000, 16'h2800, 16'h2000, 16'h0000},
  parameter logic [NSLAVE*AW-1:0] SLV_MASK = {16'hF800, 16'hF800, 16'hF800, 16'hF800, 16'hE000},
  parameter int                   MAX_OUT  = 4,
  parameter int                   TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m_cyc,
  input  logic                 m_stb,
  input  logic                 m_we,
  input  logic [AW-1:0]        m_adr,
  input  logic [DW-1:0]        m_dat_w,
  output logic                 m_stall,
  output logic                 m_ack,
  output logic                 m_err,
  output logic [DW-1:0]        m_dat_r,
  output logic [NSLAVE-1:0]    s_cyc,
  output logic [NSLAVE-1:0]    s_stb,
  output logic                 s_we,
  output logic [AW-1:0]        s_adr,
  output logic [DW-1:0]        s_dat_w,
  input  logic [NSLAVE-1:0]    s_stall,
  input  logic [NSLAVE-1:0]    s_ack,
  input  logic [NSLAVE-1:0]    s_err,
  input  logic [NSLAVE*DW-1:0] s_dat_r
);

  localparam int C_TW = $clog2(NSLAVE + 1);
  localparam int C_PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int C_CW = $clog2(MAX_OUT + 1);
  localparam int C_WW = $clog2(TIMEOUT + 1);
  localparam logic [C_TW-1:0] C_UNMAPPED = C_TW'(NSLAVE);

  // Order FIFO and bookkeeping
  logic [C_TW-1:0] r_fifo [MAX_OUT];
  logic [C_PW-1:0] r_rd, r_wr;
  logic [C_CW-1:0] r_cnt;
  logic [C_WW-1:0] r_wd;
  logic            r_int_err;
  logic [C_TW-1:0] r_last;

  logic [C_TW-1:0] w_target;
  logic [C_TW-1:0] w_head;
  logic            w_tgt_stall;
  logic            w_h_ack, w_h_err;
  logic [DW-1:0]   w_h_dat;
  logic            w_empty, w_full, w_switch, w_block;
  logic            w_head_map, w_s_ack, w_s_err, w_resp, w_wd_fire;
  logic            w_push, w_pop;
  logic [C_PW-1:0] w_rd_nxt, w_wr_nxt;
  logic [C_CW-1:0] w_cnt_nxt;
  logic [C_WW-1:0] w_wd_nxt;
  logic            w_int_err_nxt;
  logic [C_TW-1:0] w_last_nxt;

  function automatic logic [C_PW-1:0] f_inc(input logic [C_PW-1:0] p);
    if (p == C_PW'(MAX_OUT - 1)) return '0;
    return p + C_PW'(1);
  endfunction

  // Address decode: scanning downwards lets the lowest hitting index win.
  always_comb begin
    w_target = C_UNMAPPED;
    for (int i = NSLAVE - 1; i >= 0; i--) begin
      if ((m_adr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) w_target = C_TW'(i);
    end
  end

  assign w_head = r_fifo[r_rd];

  // Per-slave muxes; the unmapped index matches no slave and yields zeros.
  always_comb begin
    w_tgt_stall = 1'b0;
    w_h_ack     = 1'b0;
    w_h_err     = 1'b0;
    w_h_dat     = '0;
    for (int i = 0; i < NSLAVE; i++) begin
      if (w_target == C_TW'(i)) w_tgt_stall = s_stall[i];
      if (w_head == C_TW'(i)) begin
        w_h_ack = s_ack[i];
        w_h_err = s_err[i];
        w_h_dat = s_dat_r[i*DW +: DW];
      end
    end
  end

  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == C_CW'(MAX_OUT));
  // Every queued entry shares r_last, so a different target must wait for
  // the queue to drain; this keeps responses in request order.
  assign w_switch = !w_empty && (w_target != r_last);
  assign w_block  = w_full | w_switch;

  // Request-side outputs are forced low while reset is asserted.
  assign m_stall  = rst_n & (w_block | w_tgt_stall);
  assign w_push   = m_cyc & m_stb & !m_stall;

  assign s_we     = m_we;
  assign s_adr    = m_adr;
  assign s_dat_w  = m_dat_w;

  generate
    for (genvar g = 0; g < NSLAVE; g++) begin : g_slave
      assign s_stb[g] = rst_n & m_cyc & m_stb & (w_target == C_TW'(g)) & !w_block;
      assign s_cyc[g] = rst_n & m_cyc & (s_stb[g] | (!w_empty & (r_last == C_TW'(g))));
    end
  endgenerate

  // Response side
  assign w_head_map = !w_empty && (w_head != C_UNMAPPED);
  assign w_s_ack    = w_head_map & w_h_ack;
  assign w_s_err    = w_head_map & w_h_err;
  assign w_resp     = w_s_ack | w_s_err | r_int_err;
  assign w_wd_fire  = !w_empty && (r_wd == C_WW'(TIMEOUT)) && !w_resp;
  assign w_pop      = m_cyc & w_resp;

  assign m_ack   = m_cyc & w_s_ack;
  assign m_err   = m_cyc & (w_s_err | r_int_err | w_wd_fire);
  assign m_dat_r = w_head_map ? w_h_dat : '0;

  // Next-state for the FIFO, watchdog and internal responder
  always_comb begin
    w_rd_nxt      = r_rd;
    w_wr_nxt      = r_wr;
    w_cnt_nxt     = r_cnt;
    w_wd_nxt      = r_wd;
    w_int_err_nxt = 1'b0;
    w_last_nxt    = w_push ? w_target : r_last;
    if (!m_cyc) begin
      w_rd_nxt  = '0;
      w_wr_nxt  = '0;
      w_cnt_nxt = '0;
      w_wd_nxt  = '0;
    end else begin
      if (w_wd_fire) begin
        // Flush: everything queued so far is dropped, a same-cycle push survives.
        w_rd_nxt  = r_wr;
        w_cnt_nxt = '0;
      end else if (w_pop) begin
        w_rd_nxt  = f_inc(r_rd);
        w_cnt_nxt = r_cnt - C_CW'(1);
      end
      if (w_push) begin
        w_wr_nxt  = f_inc(r_wr);
        w_cnt_nxt = w_cnt_nxt + C_CW'(1);
      end
      if (w_wd_fire || w_resp || w_empty) w_wd_nxt = '0;
      else                                w_wd_nxt = r_wd + C_WW'(1);
      // The next head is the newest target whenever the queue stays non-empty,
      // so the internal error is raised for the cycle in which it is head.
      w_int_err_nxt = (w_cnt_nxt != '0) && (w_last_nxt == C_UNMAPPED);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd      <= '0;
      r_wr      <= '0;
      r_cnt     <= '0;
      r_wd      <= '0;
      r_int_err <= 1'b0;
      r_last    <= '0;
      for (int k = 0; k < MAX_OUT; k++) r_fifo[k] <= '0;
    end else begin
      r_rd      <= w_rd_nxt;
      r_wr      <= w_wr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_wd      <= w_wd_nxt;
      r_int_err <= w_int_err_nxt;
      r_last    <= w_last_nxt;
      if (w_push) r_fifo[r_wr] <= w_target;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_intercon_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_intercon_n
// Purpose  : Self-checking bench for wb_intercon_n: a decode/routing vector
//            table followed by directed multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_intercon_n;

  logic        clk;
  logic        rst_n;
  logic        m_cyc, m_stb, m_we;
  logic [15:0] m_adr, m_dat_w;
  logic        m_stall, m_ack, m_err;
  logic [15:0] m_dat_r;
  logic [4:0]  s_cyc, s_stb;
  logic        s_we;
  logic [15:0] s_adr, s_dat_w;
  logic [4:0]  s_stall, s_ack, s_err;
  logic [79:0] s_dat_r;

  int total = 0;
  int bad   = 0;

  wb_intercon_n dut (
    .clk(clk), .rst_n(rst_n),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_w(m_dat_w),
    .m_stall(m_stall), .m_ack(m_ack), .m_err(m_err), .m_dat_r(m_dat_r),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w),
    .s_stall(s_stall), .s_ack(s_ack), .s_err(s_err), .s_dat_r(s_dat_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cyc;
    logic        stb;
    logic [15:0] adr;
    logic [4:0]  sstall;
    logic [4:0]  sack;
    logic [4:0]  serr;
    logic [4:0]  e_stb;
    logic [4:0]  e_cyc;
    logic        e_stall;
    logic        e_ack;
    logic        e_err;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Step to 2 ns after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_adr = '0; m_dat_w = '0;
    s_stall = '0; s_ack = '0; s_err = '0; s_dat_r = '0;
  endtask

  task automatic req(input logic [15:0] adr);
    m_cyc = 1'b1; m_stb = 1'b1; m_adr = adr;
  endtask

  initial begin
    int n;

    vecs[0]  = '{1'b1, 1'b1, 16'h0100, 5'h00, 5'h00, 5'h00, 5'b00001, 5'b00001, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 16'h1FFF, 5'h00, 5'h00, 5'h00, 5'b00001, 5'b00001, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 16'h2000, 5'h00, 5'h00, 5'h00, 5'b00010, 5'b00010, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 16'h27FF, 5'h00, 5'h00, 5'h00, 5'b00010, 5'b00010, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 16'h2800, 5'h00, 5'h00, 5'h00, 5'b00100, 5'b00100, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 16'h3000, 5'h00, 5'h00, 5'h00, 5'b01000, 5'b01000, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 16'h3FFF, 5'h00, 5'h00, 5'h00, 5'b10000, 5'b10000, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 16'h8000, 5'h00, 5'h00, 5'h00, 5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 16'h4000, 5'h00, 5'h00, 5'h00, 5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 16'h3000, 5'h08, 5'h00, 5'h00, 5'b01000, 5'b01000, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 16'h3000, 5'h02, 5'h00, 5'h00, 5'b01000, 5'b01000, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 16'h2000, 5'h00, 5'h1F, 5'h1F, 5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 16'h0100, 5'h00, 5'h1F, 5'h00, 5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0};

    idle_inputs();
    rst_n = 1'b0;

    // ---- reset state, with a request driven on the master side
    tick();
    req(16'h0100);
    #1;
    chk("rst_s_stb",   s_stb,   5'b0);
    chk("rst_s_cyc",   s_cyc,   5'b0);
    chk("rst_m_stall", m_stall, 1'b0);
    chk("rst_m_ack",   m_ack,   1'b0);
    chk("rst_m_err",   m_err,   1'b0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // ---- decode / routing table, FIFO kept empty by dropping m_cyc before each edge
    for (int v = 0; v < 13; v++) begin
      tick();
      m_cyc = vecs[v].cyc; m_stb = vecs[v].stb; m_adr = vecs[v].adr;
      s_stall = vecs[v].sstall; s_ack = vecs[v].sack; s_err = vecs[v].serr;
      #1;
      chk($sformatf("vec%0d_s_stb", v),   s_stb,   vecs[v].e_stb);
      chk($sformatf("vec%0d_s_cyc", v),   s_cyc,   vecs[v].e_cyc);
      chk($sformatf("vec%0d_m_stall", v), m_stall, vecs[v].e_stall);
      chk($sformatf("vec%0d_m_ack", v),   m_ack,   vecs[v].e_ack);
      chk($sformatf("vec%0d_m_err", v),   m_err,   vecs[v].e_err);
      #1;
      idle_inputs();
    end

    // ---- ROM read, 1-cycle ack with 0xBEEF
    tick();
    req(16'h0100);
    #1;
    chk("rom_stb", s_stb, 5'b00001);
    chk("rom_stall", m_stall, 1'b0);
    tick();
    m_stb = 1'b0; s_ack = 5'b00001; s_dat_r[15:0] = 16'hBEEF;
    #1;
    chk("rom_stb_once", s_stb, 5'b0);
    chk("rom_ack", m_ack, 1'b1);
    chk("rom_dat", m_dat_r, 16'hBEEF);
    chk("rom_cyc_hold", s_cyc, 5'b00001);
    tick();
    s_ack = '0;
    #1;
    chk("rom_ack_once", m_ack, 1'b0);
    chk("rom_cyc_end", s_cyc, 5'b0);
    chk("rom_dat_empty", m_dat_r, 16'h0);
    idle_inputs();

    // ---- four pipelined RAM reads, fifth stalls at full, acks in order
    for (int k = 0; k < 4; k++) begin
      tick();
      req(16'h2000 + 16'(k));
      #1;
      chk($sformatf("pipe_stall%0d", k), m_stall, 1'b0);
      chk($sformatf("pipe_stb%0d", k), s_stb, 5'b00010);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      req(16'h2004);
      #1;
      chk($sformatf("pipe_full_stall%0d", k), m_stall, 1'b1);
      chk($sformatf("pipe_full_stb%0d", k), s_stb, 5'b0);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k >= 2) m_stb = 1'b0;
      s_ack = 5'b00010; s_dat_r[31:16] = 16'hA000 + 16'(k);
      #1;
      chk($sformatf("pipe_ack%0d", k), m_ack, 1'b1);
      chk($sformatf("pipe_dat%0d", k), m_dat_r, 16'hA000 + 16'(k));
      if (k == 0) chk("pipe_full_pop_stall", m_stall, 1'b1);
      if (k == 1) chk("pipe_fifth_accept", m_stall, 1'b0);
    end
    tick();
    s_ack = '0;
    #1;
    chk("pipe_drained_ack", m_ack, 1'b0);
    chk("pipe_drained_cyc", s_cyc, 5'b0);
    idle_inputs();

    // ---- read RAM then write slave 3: switch waits for the RAM ack
    tick();
    req(16'h2000);
    tick();
    req(16'h3000); m_we = 1'b1; m_dat_w = 16'h5555;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) s_ack = 5'b00010;
      #1;
      chk($sformatf("sw_stall%0d", k), m_stall, 1'b1);
      chk($sformatf("sw_cyc%0d", k), s_cyc, 5'b00010);
      if (k == 2) chk("sw_ram_ack", m_ack, 1'b1);
      tick();
    end
    s_ack = '0;
    #1;
    chk("sw_go_stall", m_stall, 1'b0);
    chk("sw_go_stb", s_stb, 5'b01000);
    chk("sw_go_we", s_we, 1'b1);
    chk("sw_go_dat", s_dat_w, 16'h5555);
    tick();
    m_stb = 1'b0; s_ack = 5'b01000;
    #1;
    chk("sw_wr_ack", m_ack, 1'b1);
    chk("sw_wr_cyc", s_cyc, 5'b01000);
    idle_inputs();

    // ---- unmapped access: internal error one cycle after acceptance
    tick();
    req(16'h8000);
    #1;
    chk("unm_stb", s_stb, 5'b0);
    chk("unm_stall", m_stall, 1'b0);
    chk("unm_err_early", m_err, 1'b0);
    tick();
    m_stb = 1'b0;
    #1;
    chk("unm_err", m_err, 1'b1);
    chk("unm_ack", m_ack, 1'b0);
    tick();
    #1;
    chk("unm_err_once", m_err, 1'b0);
    idle_inputs();

    // ---- watchdog: slave 1 never acks
    tick();
    req(16'h2000);
    n = 0;
    for (int k = 1; k <= 400; k++) begin
      tick();
      m_stb = 1'b0;
      #1;
      if (m_err === 1'b1) begin
        n = k;
        break;
      end
    end
    chk("wd_cycles", n, 256);
    tick();
    #1;
    chk("wd_err_once", m_err, 1'b0);
    chk("wd_flushed_cyc", s_cyc, 5'b0);
    chk("wd_next_stall", m_stall, 1'b0);
    req(16'h0100);
    tick();
    m_stb = 1'b0; s_ack = 5'b00001; s_dat_r[15:0] = 16'h1234;
    #1;
    chk("wd_after_ack", m_ack, 1'b1);
    chk("wd_after_dat", m_dat_r, 16'h1234);
    idle_inputs();

    // ---- abort with two outstanding, then a late ack
    tick();
    req(16'h2000);
    tick();
    req(16'h2001);
    tick();
    m_cyc = 1'b0; m_stb = 1'b0;
    #1;
    chk("abort_cyc_low", s_cyc, 5'b0);
    tick();
    s_ack = 5'b00010;
    #1;
    chk("abort_ack_nocyc", m_ack, 1'b0);
    tick();
    m_cyc = 1'b1;
    #1;
    chk("abort_late_ack", m_ack, 1'b0);
    chk("abort_empty_cyc", s_cyc, 5'b0);
    idle_inputs();

    // ---- reset mid-burst
    tick();
    req(16'h2000);
    tick();
    req(16'h2001);
    #2;
    rst_n = 1'b0;
    s_ack = 5'b00010;
    #1;
    chk("mrst_s_cyc", s_cyc, 5'b0);
    chk("mrst_s_stb", s_stb, 5'b0);
    chk("mrst_m_ack", m_ack, 1'b0);
    chk("mrst_m_err", m_err, 1'b0);
    chk("mrst_m_stall", m_stall, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    m_stb = 1'b0;
    tick();
    #1;
    chk("mrst_after_ack", m_ack, 1'b0);
    chk("mrst_after_cyc", s_cyc, 5'b0);
    idle_inputs();

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
